// File: rtl/lgn_pkg.sv
// Shared types and width helpers for the LGN group-sum / argmax readout.
package lgn_pkg;

  // Frame-processing phases of the readout controller.
  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_ARGMAX = 2'd1,
    ST_HOLD   = 2'd2
  } lgn_state_e;

  // Ceiling log2 usable in constant expressions; lgn_clog2(1) = 0.
  function automatic int lgn_clog2(input int value);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < value) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Clamp a width to at least one bit.
  function automatic int lgn_max1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/lgn_popcount.sv
// Combinational population count of a W-bit vector.
module lgn_popcount
  import lgn_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = lgn_clog2(W + 1)
) (
  input  logic [W-1:0]     bits,
  output logic [CNT_W-1:0] count
);

  // Sum the set bits; synthesis builds an adder tree from this chain.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/lgn_groupsum_argmax.sv
// Group-sum readout for a logic-gate network: popcounts each class's slice
// of the final-layer gate outputs over up to BEATS beats, then reports the
// class with the highest score (lowest index wins ties).
module lgn_groupsum_argmax
  import lgn_pkg::*;
#(
  parameter  int N_CLASS = 4,
  parameter  int GROUP   = 8,
  parameter  int BEATS   = 2,
  localparam int SCORE_W = lgn_clog2(GROUP * BEATS + 1),
  localparam int CLS_W   = lgn_max1(lgn_clog2(N_CLASS))
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_CLASS*GROUP-1:0]   in_bits,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLS_W-1:0]           out_class,
  output logic [SCORE_W-1:0]         out_score,
  output logic [N_CLASS*SCORE_W-1:0] out_scores,
  output logic                       err_overrun
);

  localparam int PC_W   = lgn_clog2(GROUP + 1);
  localparam int BCNT_W = lgn_max1(lgn_clog2(BEATS + 1));

  lgn_state_e          state;
  logic [SCORE_W-1:0]  acc_p0 [N_CLASS];
  logic [BCNT_W-1:0]   beat_cnt_p0;
  logic [PC_W-1:0]     pc [N_CLASS];

  logic                accept;
  logic                at_max_beat;
  logic                frame_end;
  logic                release_hold;
  logic [CLS_W-1:0]    best_class;
  logic [SCORE_W-1:0]  best_score;

  for (genvar c = 0; c < N_CLASS; c++) begin : g_pc
    lgn_popcount #(
      .W     (GROUP),
      .CNT_W (PC_W)
    ) u_popcount (
      .bits  (in_bits[c*GROUP +: GROUP]),
      .count (pc[c])
    );
  end

  assign in_ready     = (state == ST_ACCUM);
  assign out_valid    = (state == ST_HOLD);
  assign accept       = in_valid & in_ready;
  assign at_max_beat  = (beat_cnt_p0 == BCNT_W'(BEATS - 1));
  assign frame_end    = accept & (in_last | at_max_beat);
  assign release_hold = out_valid & out_ready;

  // Linear scan with strict greater-than so equal scores keep the lower index.
  always_comb begin
    best_class = '0;
    best_score = acc_p0[0];
    for (int c = 1; c < N_CLASS; c++) begin
      if (acc_p0[c] > best_score) begin
        best_class = CLS_W'(c);
        best_score = acc_p0[c];
      end
    end
  end

  // Controller: accumulate a frame, spend one cycle on argmax, hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM:  if (frame_end)    state <= ST_ARGMAX;
        ST_ARGMAX:                   state <= ST_HOLD;
        ST_HOLD:   if (release_hold) state <= ST_ACCUM;
        default:                     state <= ST_ACCUM;
      endcase
    end
  end

  // Stage p0: per-class score accumulation and beat counting within a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_p0 <= '0;
      for (int c = 0; c < N_CLASS; c++) acc_p0[c] <= '0;
    end else if (release_hold) begin
      beat_cnt_p0 <= '0;
      for (int c = 0; c < N_CLASS; c++) acc_p0[c] <= '0;
    end else if (accept) begin
      beat_cnt_p0 <= beat_cnt_p0 + BCNT_W'(1);
      for (int c = 0; c < N_CLASS; c++) acc_p0[c] <= acc_p0[c] + SCORE_W'(pc[c]);
    end
  end

  // Stage p1: capture the argmax result and all scores; stable through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_class  <= '0;
      out_score  <= '0;
      out_scores <= '0;
    end else if (state == ST_ARGMAX) begin
      out_class <= best_class;
      out_score <= best_score;
      for (int c = 0; c < N_CLASS; c++) out_scores[c*SCORE_W +: SCORE_W] <= acc_p0[c];
    end
  end

  // Sticky flag: a frame was cut off at BEATS beats without in_last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overrun <= 1'b0;
    end else if (accept & at_max_beat & ~in_last) begin
      err_overrun <= 1'b1;
    end
  end

endmodule
